// File: rtl/aes_key_schedule_serial.sv
// Byte-serial AES-128 key expansion: streams 11 round keys, one byte per advance.
// Optional AES_KS_KEY_RETAIN_EN keeps a master key copy for reuse after done.
module bSbox (
  input  logic [7:0] a,
  input  logic       encrypt,
  output logic [7:0] q
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  logic [7:0] fwd;
  logic [7:0] inv;
  logic [7:0] pre;
  logic [7:0] post;

  always_comb begin
    post = gf_inv(a);
    fwd  = post ^ rotl(post, 1) ^ rotl(post, 2) ^ rotl(post, 3) ^ rotl(post, 4) ^ 8'h63;
    pre  = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
    inv  = gf_inv(pre);
    q    = encrypt ? fwd : inv;
  end

endmodule

module aes_key_schedule_serial #(
  parameter int KEY_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       key_load,
  input  logic       start,
  input  logic       advance,
  output logic [7:0] round_key_delayed,
  output logic [7:0] round_key_last,
  output logic [3:0] round_cnt,
  output logic [3:0] byte_cnt,
  output logic       key_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY,
    RUN
  } state_t;

  state_t state;

  logic [15:0][7:0] kreg;
`ifdef AES_KS_KEY_RETAIN_EN
  logic [15:0][7:0] mreg;
`endif
  logic [7:0] rcon;
  logic [7:0] sb_in;
  logic [7:0] sb_out;
  logic [7:0] nbyte;
  logic [KEY_DELAY-1:0][7:0] dline;
  logic       emit;
  logic       last_byte;

  assign emit      = (state == RUN) && advance;
  assign last_byte = (round_cnt == 4'd10) && (byte_cnt == 4'd15);
  assign sb_in     = (byte_cnt == 4'd3) ? kreg[9] : kreg[13];

  bSbox u_sbox (
    .a      (sb_in),
    .encrypt(1'b1),
    .q      (sb_out)
  );

  // bytes 0..3 of a round take the rotated, substituted last word
  always_comb begin
    nbyte = kreg[0] ^ kreg[12];
    unique case (1'b1)
      byte_cnt == 4'd0: nbyte = kreg[0] ^ sb_out ^ rcon;
      byte_cnt == 4'd1,
      byte_cnt == 4'd2,
      byte_cnt == 4'd3: nbyte = kreg[0] ^ sb_out;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      kreg      <= '0;
`ifdef AES_KS_KEY_RETAIN_EN
      mreg      <= '0;
`endif
      rcon      <= 8'h00;
      round_cnt <= 4'd0;
      byte_cnt  <= 4'd0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, READY: begin
          if (key_load) begin
            kreg      <= {key_in, kreg[15:1]};
`ifdef AES_KS_KEY_RETAIN_EN
            mreg      <= {key_in, mreg[15:1]};
`endif
            byte_cnt  <= 4'd1;
            key_ready <= 1'b0;
            state     <= LOAD;
          end else if (state == READY && start) begin
            round_cnt <= 4'd0;
            byte_cnt  <= 4'd0;
            rcon      <= 8'h01;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        LOAD: begin
          if (key_load) begin
            kreg     <= {key_in, kreg[15:1]};
`ifdef AES_KS_KEY_RETAIN_EN
            mreg     <= {key_in, mreg[15:1]};
`endif
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              key_ready <= 1'b1;
              state     <= READY;
            end
          end
        end
        RUN: begin
          if (advance) begin
            kreg <= {nbyte, kreg[15:1]};
            if (last_byte) begin
              round_cnt <= 4'd0;
              byte_cnt  <= 4'd0;
              busy      <= 1'b0;
              done      <= 1'b1;
`ifdef AES_KS_KEY_RETAIN_EN
              kreg      <= mreg;
              key_ready <= 1'b1;
              state     <= READY;
`else
              state     <= IDLE;
`endif
            end else if (byte_cnt == 4'd15) begin
              byte_cnt  <= 4'd0;
              round_cnt <= round_cnt + 4'd1;
              rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stalls push zeros through so the consumer sees gaps in place
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dline          <= '0;
      round_key_last <= 8'h00;
    end else begin
      dline[0]       <= (emit && round_cnt != 4'd10) ? kreg[0] : 8'h00;
      for (int k = 1; k < KEY_DELAY; k++) dline[k] <= dline[k-1];
      round_key_last <= (emit && round_cnt == 4'd10) ? kreg[0] : 8'h00;
    end
  end

  assign round_key_delayed = dline[KEY_DELAY-1];

endmodule

// File: tb/tb_aes_key_schedule_serial.sv
// Self-checking bench for aes_key_schedule_serial (FIPS-197 word model).
// Honors AES_KS_KEY_RETAIN_EN when the build defines it.
module tb_aes_key_schedule_serial;

  localparam int KD = 1;
`ifdef AES_KS_KEY_RETAIN_EN
  localparam bit RETAIN = 1'b1;
`else
  localparam bit RETAIN = 1'b0;
`endif
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_in;
  logic       key_load;
  logic       start;
  logic       advance;
  logic [7:0] round_key_delayed;
  logic [7:0] round_key_last;
  logic [3:0] round_cnt;
  logic [3:0] byte_cnt;
  logic       key_ready;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  aes_key_schedule_serial #(.KEY_DELAY(KD)) dut (
    .clk              (clk),
    .rst              (rst),
    .key_in           (key_in),
    .key_load         (key_load),
    .start            (start),
    .advance          (advance),
    .round_key_delayed(round_key_delayed),
    .round_key_last   (round_key_last),
    .round_cnt        (round_cnt),
    .byte_cnt         (byte_cnt),
    .key_ready        (key_ready),
    .busy             (busy),
    .done             (done)
  );

  int vec = 0;
  int err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference S-box: brute-force inverse plus bitwise affine map
  logic [7:0] sbox_t[256];

  function automatic int gmul(input int a, input int b);
    int p;
    int x;
    p = 0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (((b >> k) & 1) == 1) p = p ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11b;
    end
    return p;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      int inv;
      logic [7:0] s;
      logic [7:0] c;
      inv = 0;
      c = 8'h63;
      for (int y = 1; y < 256; y++)
        if (gmul(x, y) == 1) inv = y;
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  end

  // FIPS-197 word recurrence; returns byte n (0..175) of the expanded key
  function automatic logic [7:0] ks_byte(input logic [7:0] key[16], input int n);
    logic [31:0] w[44];
    logic [31:0] t;
    int rc;
    for (int i = 0; i < 4; i++)
      w[i] = {key[4*i], key[4*i+1], key[4*i+2], key[4*i+3]};
    rc = 1;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc[7:0], 24'h0};
        rc = gmul(rc, 2);
      end
      w[i] = w[i-4] ^ t;
    end
    t = w[n/4];
    return t[31-8*(n%4) -: 8];
  endfunction

  logic [7:0] m_lkey[16];
  logic [7:0] m_runkey[16];
  logic [7:0] m_dly[KD];
  logic [7:0] m_last;
  bit         m_run, m_ready, m_loading, m_done;
  int         m_lcnt, m_idx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run     <= 1'b0;
      m_ready   <= 1'b0;
      m_loading <= 1'b0;
      m_done    <= 1'b0;
      m_lcnt    <= 0;
      m_idx     <= 0;
      m_last    <= 8'h00;
      for (int k = 0; k < KD; k++) m_dly[k] <= 8'h00;
    end else begin
      m_done   <= 1'b0;
      m_dly[0] <= (m_run && advance && m_idx < 160) ? ks_byte(m_runkey, m_idx) : 8'h00;
      for (int k = 1; k < KD; k++) m_dly[k] <= m_dly[k-1];
      m_last   <= (m_run && advance && m_idx >= 160) ? ks_byte(m_runkey, m_idx) : 8'h00;
      if (m_run) begin
        if (advance) begin
          m_idx <= m_idx + 1;
          if (m_idx == 175) begin
            m_run   <= 1'b0;
            m_done  <= 1'b1;
            m_ready <= RETAIN;
          end
        end
      end else if (key_load) begin
        m_lkey[m_lcnt] <= key_in;
        if (m_lcnt == 15) begin
          m_lcnt    <= 0;
          m_loading <= 1'b0;
          m_ready   <= 1'b1;
        end else begin
          m_lcnt    <= m_lcnt + 1;
          m_loading <= 1'b1;
          m_ready   <= 1'b0;
        end
      end else if (m_ready && start) begin
        m_run   <= 1'b1;
        m_ready <= 1'b0;
        m_idx   <= 0;
        for (int k = 0; k < 16; k++) m_runkey[k] <= m_lkey[k];
      end
    end
  end

  always @(negedge clk) begin
    chk("delayed", 128'(round_key_delayed), 128'(m_dly[KD-1]));
    chk("last", 128'(round_key_last), 128'(m_last));
    chk("busy", 128'(busy), 128'(m_run));
    chk("key_ready", 128'(key_ready), 128'(m_ready));
    chk("done", 128'(done), 128'(m_done));
    if (m_run) begin
      chk("round_cnt", 128'(round_cnt), 128'(m_idx / 16));
      chk("byte_cnt", 128'(byte_cnt), 128'(m_idx % 16));
    end else if (m_loading) begin
      chk("load_cnt", 128'(byte_cnt), 128'(m_lcnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_key(input logic [127:0] k, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      key_in   = k[127-8*i -: 8];
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_stream(input int mode, input int budget, input bit junk);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      advance = (mode == 0) ? 1'b1 : (n % 2 == 0);
      if (junk) begin
        key_load = (n % 7 == 3);
        start    = (n % 11 == 5);
        key_in   = 8'(n);
      end
      @(negedge clk);
      if (done) begin
        seen     = 1'b1;
        advance  = 1'b0;
        key_load = 1'b0;
        start    = 1'b0;
      end
      tick();
    end
    advance  = 1'b0;
    key_load = 1'b0;
    start    = 1'b0;
    chk("stream_done", 128'(seen), 128'(1));
  endtask

  logic [7:0]   cap[176];
  logic [7:0]   pin_key[16];
  logic [127:0] v;
  int           dn;
  bit           hit;

  initial begin
    rst = 1'b0;
    key_in = 8'h00;
    key_load = 1'b0;
    start = 1'b0;
    advance = 1'b0;
    repeat (3) tick();
    chk("reset_outs", 128'({round_key_delayed, round_key_last, round_cnt, byte_cnt,
                            key_ready, busy, done}), 128'(0));
    rst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) pin_key[i] = KEY1[127-8*i -: 8];
    chk("pin_sbox00", 128'(sbox_t[8'h00]), 128'(8'h63));
    chk("pin_sbox53", 128'(sbox_t[8'h53]), 128'(8'hed));
    chk("pin_ks16", 128'(ks_byte(pin_key, 16)), 128'(8'ha0));
    chk("pin_ks175", 128'(ks_byte(pin_key, 175)), 128'(8'ha6));

    // full stream, advance held high
    load_key(KEY1, 0, 15);
    chk("ready_after_load", 128'(key_ready), 128'(1));
    start = 1'b1;
    advance = 1'b1;
    tick();
    start = 1'b0;
    dn = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n - 1 - KD >= 0 && n - 1 - KD < 160) cap[n-1-KD] = round_key_delayed;
      if (n - 2 >= 160 && n - 2 < 176) cap[n-2] = round_key_last;
      if (done) begin
        dn = n;
        break;
      end
    end
    advance = 1'b0;
    tick();
    chk("done_latency", 128'(dn), 128'(177));
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], cap[i]};
    chk("round0_bytes", v, KEY1);
    for (int i = 16; i < 32; i++) v = {v[119:0], cap[i]};
    chk("round1_bytes", v, 128'ha0fafe1788542cb123a339392a6c7605);
    for (int i = 160; i < 176; i++) v = {v[119:0], cap[i]};
    chk("round10_bytes", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // stalled stream
    load_key(KEY1, 0, 15);
    pulse_start();
    run_stream(1, 600, 1'b0);

    // early start is ignored, then complete the load
    load_key(KEY2, 0, 9);
    pulse_start();
    tick();
    chk("early_start_ready", 128'(key_ready), 128'(0));
    chk("early_start_busy", 128'(busy), 128'(0));
    load_key(KEY2, 10, 15);
    pulse_start();
    run_stream(0, 300, 1'b0);

    // reset mid-run at round 5 byte 7
    load_key(KEY2, 0, 15);
    pulse_start();
    advance = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (round_cnt == 4'd5 && byte_cnt == 4'd7) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_r5b7", 128'(hit), 128'(1));
    #1;
    rst = 1'b0;
    advance = 1'b0;
    #1;
    chk("midrun_reset", 128'({round_key_delayed, round_key_last, round_cnt, byte_cnt,
                              key_ready, busy, done}), 128'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    load_key(KEY1, 0, 15);
    pulse_start();
    run_stream(0, 300, 1'b0);

    // key_load/start noise during RUN
    load_key(KEY2, 0, 15);
    pulse_start();
    run_stream(0, 300, 1'b1);

    // back-to-back start after done
    load_key(KEY1, 0, 15);
    pulse_start();
    run_stream(0, 300, 1'b0);
    pulse_start();
`ifdef AES_KS_KEY_RETAIN_EN
    run_stream(0, 300, 1'b0);
`else
    advance = 1'b1;
    repeat (4) tick();
    advance = 1'b0;
    chk("second_start_busy", 128'(busy), 128'(0));
    chk("second_start_ready", 128'(key_ready), 128'(0));
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_schedule_serial.md
# aes_key_schedule_serial

Byte-serial AES-128 key expansion engine that feeds the byte-serial AES datapath core with round-key bytes. It loads the 16-byte cipher key one byte per cycle. It then streams all 11 round keys (176 bytes), one byte per advance cycle, computing each next round key on the fly in a 16-byte shift register through a single S-box. Round keys 0–9 are presented on the AddRoundKey path; round key 10 is presented on the final-round path.

## Interface
- KEY_DELAY, 1, register stages (≥1) between byte emission and `round_key_delayed`.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low.
- key_in  input  8  cipher key byte, FIPS-197 byte order (byte 0 first).
- key_load  input  1  `key_in` valid this cycle.
- start  input  1  single-cycle pulse; begins round-key streaming.
- advance  input  1  emit one round-key byte this cycle; low stalls.
- round_key_delayed  output  8  round 0–9 key byte, delayed KEY_DELAY cycles; 0 otherwise.
- round_key_last  output  8  round 10 key byte, delayed 1 cycle; 0 otherwise.
- round_cnt  output  4  round of the next byte to emit (0–10).
- byte_cnt  output  4  byte index within the round of the next byte to emit (0–15).
- key_ready  output  1  a complete key is held and `start` will be accepted.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on emission of byte 175.

## Operation
- States: IDLE (no key), LOAD, READY, RUN.
- IDLE/READY + key_load: capture `key_in` into reg[15] and shift toward reg[0]; byte_cnt=1; go to LOAD. In LOAD, each key_load cycle shifts in one byte. After the 16th byte, go to READY. Gaps with key_load=0 hold the count.
- READY + start (key_load=0): go to RUN; round_cnt=0, byte_cnt=0, rcon=0x01.
- RUN, advance=1, with byte index i=byte_cnt:
  - emit reg[0]; shift reg left by one; reg[15] ← new byte.
  - i≥4: new = reg[0] ^ reg[12].
  - i=0..2: new = reg[0] ^ S(reg[13]) ^ (i==0 ? rcon : 0).
  - i=3: new = reg[0] ^ S(reg[9]).
  - S is the existing bSbox instance with encrypt tied 1; the S-box input mux selects reg[13] for i<3 and reg[9] for i=3.
- At i=15, byte_cnt wraps to 0, round_cnt increments, and rcon ← xtime(rcon) (0x80→0x1B, 8-bit reduction by 0x11B).
- Emitted bytes go to `round_key_delayed` for round_cnt 0–9 and to `round_key_last` for round 10. The inactive output carries 0.
- During round 10, the new-byte computation is don't-care; the register content after `done` is unspecified unless retained (see Configuration).
- Simultaneous or illegal events:
  - key_load with start in READY: key_load wins.
  - key_load or start during RUN: ignored.
  - start in IDLE or LOAD: ignored.
  - advance outside RUN: ignored.
- Reset (any time, including mid-LOAD or mid-RUN):
  - state IDLE; reg, counters, rcon and the delay line cleared.
  - all outputs 0.

## Timing
- Emission latency:
  - `round_key_last`: the byte appears 1 cycle after its advance cycle.
  - `round_key_delayed`: the byte appears KEY_DELAY cycles after its advance cycle.
- Delay lines shift every cycle and insert 0 on non-emitting cycles, so stalls show as 0 bytes.
- key_ready rises the cycle after the 16th key_load.
- busy rises the cycle after start is accepted.
- done is registered, asserting the cycle after the advance cycle of round 10 byte 15. busy falls that same cycle.
- A full stream takes 176 advance cycles; with advance tied high, done is asserted at start+177.

## Configuration
- AES_KS_KEY_RETAIN_EN defined:
  - a 16-byte master copy is captured during LOAD.
  - on done, reg is restored from the copy and the state returns to READY (key_ready=1), so back-to-back blocks need no reload.
- Not defined: on done the state returns to IDLE and key_ready=0; a new load is required before the next start.

## Test plan
- Load 2b7e151628aed2a6abf7158809cf4f3c, start, advance=1:
  - round_key_delayed bytes 0–15 equal the key.
  - bytes 16–31 are a0fafe1788542cb123a339392a6c7605.
  - round_key_last bytes are d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done at start+177.
- Same key, advance toggled 1/0: identical byte sequence with a 0 inserted per stall cycle; round_cnt/byte_cnt hold while advance=0.
- start before the 16th key byte → ignored, key_ready=0; complete the load, then start → stream correct.
- rst low at round 5 byte 7 → outputs 0 and state IDLE immediately; reload plus start gives the full correct stream.
- key_load and start pulsed during RUN → no effect on the stream.
- Back-to-back starts after done:
  - with AES_KS_KEY_RETAIN_EN, the second stream equals the first.
  - without it, key_ready=0 and the second start is ignored.
